lz77_job_scheduler: RTL and testbench
=====================================

// Module: lz77_job_scheduler
// PURPOSE
//  Round-robin scheduler sharing one LZ77_Encoder between NUM_CH requesters. Grants one channel
//  per job, pulses the encoder reset, streams BLOCK_LEN chars into it, and captures its triplets
//  into a small output FIFO tagged with the channel id. Releases the grant on encoder finish.
// PARAMETERS
//  NUM_CH      2      number of requesting channels (2..8)
//  BLOCK_LEN   2048   chars per job; must equal the encoder's buffer size
//  FIFO_DEPTH  4      output triplet FIFO entries (power of 2)
//  TIMEOUT_CYC 65535  ENCODE-phase watchdog limit (only with LZ_SCHED_TIMEOUT_EN)
// PORTS
//  clk            in   1          clock, rising edge
//  reset          in   1          asynchronous, active-high
//  ch_req         in   NUM_CH     channel i requests a job; held until ch_done[i]
//  ch_data        in   NUM_CH*8   char bus, channel i at [8i+7:8i]
//  ch_valid       in   NUM_CH     ch_data[i] valid this cycle
//  ch_gnt         out  NUM_CH     one-hot grant, high from ARB exit to job end
//  ch_ready       out  NUM_CH     char consumed this cycle (LOAD only)
//  ch_done        out  NUM_CH     1-cycle pulse: job ended (ok or error)
//  enc_rst        out  1          encoder reset
//  enc_chardata   out  8          granted channel's ch_data (0 outside LOAD)
//  enc_valid      in   1          encoder triplet strobe
//  enc_finish     in   1          encoder finished
//  enc_offset     in   4          encoder offset
//  enc_match_len  in   3          encoder match_len
//  enc_char_nxt   in   8          encoder char_nxt
//  out_valid      out  1          FIFO head valid
//  out_ready      in   1          downstream accepts head
//  out_ch         out  $clog2(NUM_CH)  channel id of head
//  out_offset     out  4          head offset
//  out_match_len  out  3          head match_len
//  out_char_nxt   out  8          head char_nxt
//  out_last       out  1          head char_nxt==8'h24 (terminal triplet)
//  err            out  1          1-cycle pulse on underrun, FIFO overflow or timeout
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0 except enc_rst=1, FIFO empty, rr pointer=NUM_CH-1.
//  IDLE: enc_rst=1. Any ch_req -> ARB next cycle.
//  ARB: grant first requester after rr pointer (wrap), update pointer -> RST. enc_rst=1 one cycle.
//  RST: enc_rst=0 from here on -> LOAD; char counter=0.
//  LOAD: ch_ready[g]=ch_valid[g]; enc_chardata=ch_data[g]. Valid char: counter+1.
//   counter==BLOCK_LEN-1 with valid -> ENCODE. Encoder takes 1 char/clock, no stall, so ch_valid
//   low in LOAD = underrun: err, ch_done[g], enc_rst=1 next cycle, -> IDLE.
//  ENCODE: each enc_valid pushes {g,offset,match_len,char_nxt} in the same cycle. Push on full
//   FIFO drops the entry, pulses err, job still runs. enc_finish -> DRAIN.
//  DRAIN: wait FIFO empty -> ch_done[g], drop grant, enc_rst=1, -> IDLE. ch_req dropped mid-job
//   is ignored; the job completes.
//  FIFO: out_valid=!empty; pop on out_valid&out_ready. Push and pop when full: both happen, no
//   overflow. Read/write pointers are log2(FIFO_DEPTH)+1 bits and wrap.
//  Only the granted channel sees ch_ready/ch_done. Async reset in any state aborts the job with no
//   ch_done or err pulse and flushes the FIFO.
// CONFIGURATION
//  LZ_SCHED_TIMEOUT_EN defined: 16-bit counter clears on ENCODE entry and counts each ENCODE
//   cycle. Reaching TIMEOUT_CYC without enc_finish: err, ch_done[g], flush FIFO, -> IDLE.
//  Not defined: no counter, and ENCODE waits indefinitely for enc_finish.
// STRUCTURE
//  Package lz77_pkg: state enum (IDLE,ARB,RST,LOAD,ENCODE,DRAIN), typedef triplet_t
//   {offset[3:0],match_len[2:0],char_nxt[7:0]}, constant LZ_EOS=8'h24.
//  One sub-module: lz77_triplet_fifo (sync FIFO, DEPTH param, full/empty).
// TESTING
//  1 ch0 req only, 2048 valid chars 0..15 repeating -> gnt=01, 2048 ch_ready, triplets out_ch=0,
//    last has out_last=1 and char_nxt=8'h24, then one ch_done[0] pulse.
//  2 ch0 and ch1 req in the same cycle from reset -> ch0 served first, then ch1. ch0 re-req ->
//    ch0 waits until ch1 finishes.
//  3 ch_valid drops at LOAD char 100 -> err pulse, ch_done pulse, enc_rst=1, FIFO empty, IDLE.
//  4 out_ready=0 through ENCODE, FIFO_DEPTH=4 -> first 4 triplets kept, err on 5th push;
//    out_ready=1 -> the 4 drain in order.
//  5 reset asserted mid-LOAD -> outputs at reset values next edge, no ch_done. Re-run test 1 ok.
//  6 (LZ_SCHED_TIMEOUT_EN) enc_finish tied 0 -> err + ch_done exactly TIMEOUT_CYC cycles after
//    ENCODE entry.

Source files
------------

// File: rtl/lz77_job_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package     : lz77_pkg
// Description : Shared types for the LZ77 job scheduler: scheduler state
//               encoding, encoder triplet layout and the end-of-stream char.
// Revision    : 1.0 - initial release
// ============================================================================
package lz77_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARB    = 3'd1,
    RST    = 3'd2,
    LOAD   = 3'd3,
    ENCODE = 3'd4,
    DRAIN  = 3'd5
  } sched_state_e;

  typedef struct packed {
    logic [3:0] offset;
    logic [2:0] match_len;
    logic [7:0] char_nxt;
  } triplet_t;

  // char_nxt value the encoder emits in its terminal triplet
  localparam logic [7:0] LZ_EOS = 8'h24;

endpackage
`default_nettype wire

// File: rtl/lz77_job_scheduler_fifo.sv
`default_nettype none
// ============================================================================
// Module      : lz77_triplet_fifo
// Description : Synchronous FIFO for tagged encoder triplets. Pointers carry
//               one extra wrap bit so full and empty are told apart without
//               a separate counter. A push into a full FIFO is accepted only
//               when a pop happens in the same cycle; otherwise it is dropped
//               and the caller flags the overflow.
// Revision    : 1.0 - initial release
// Ports       : i_clk    clock, rising edge
//               i_rst    asynchronous active-high reset (empties the FIFO)
//               i_flush  synchronous empty
//               i_push   write i_wdata
//               i_pop    advance head (ignored when empty)
//               o_rdata  head entry
//               o_full   DEPTH entries held
//               o_empty  no entries held
// Parameters  : DEPTH (power of 2, >= 2), WIDTH
// ============================================================================
module lz77_triplet_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wp;
  logic [AW:0]      r_rp;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wp == r_rp);
  assign o_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else if (i_flush) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + (AW+1)'(1);
      if (w_do_pop)  r_rp <= r_rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) r_mem[r_wp[AW-1:0]] <= i_wdata;
  end

endmodule
`default_nettype wire

// File: rtl/lz77_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : lz77_job_scheduler
// Description : Round-robin scheduler sharing one LZ77 encoder between NUM_CH
//               requesters. Per job: grant one channel, pulse encoder reset,
//               stream BLOCK_LEN chars into the encoder, capture its triplets
//               (tagged with the channel id) into an output FIFO, and end the
//               job once the encoder finishes and the FIFO has drained.
// Revision    : 1.0 - initial release
// Macro       : LZ_SCHED_TIMEOUT_EN - adds an ENCODE-phase watchdog that ends
//               the job with err after TIMEOUT_CYC cycles without enc_finish.
// Ports       : i_clk / i_reset       clock / async active-high reset
//               i_ch_req,i_ch_data,i_ch_valid  per-channel request and chars
//               o_ch_gnt,o_ch_ready,o_ch_done  per-channel grant/consume/end
//               o_enc_rst,o_enc_chardata       encoder control and char
//               i_enc_valid,i_enc_finish,i_enc_offset,i_enc_match_len,
//               i_enc_char_nxt                 encoder triplet stream
//               o_out_*, i_out_ready           FIFO head (valid/ready)
//               o_err                          underrun/overflow/timeout pulse
// ============================================================================
module lz77_job_scheduler
  import lz77_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int BLOCK_LEN   = 2048,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NUM_CH-1:0]         i_ch_req,
  input  logic [NUM_CH*8-1:0]       i_ch_data,
  input  logic [NUM_CH-1:0]         i_ch_valid,
  output logic [NUM_CH-1:0]         o_ch_gnt,
  output logic [NUM_CH-1:0]         o_ch_ready,
  output logic [NUM_CH-1:0]         o_ch_done,
  output logic                      o_enc_rst,
  output logic [7:0]                o_enc_chardata,
  input  logic                      i_enc_valid,
  input  logic                      i_enc_finish,
  input  logic [3:0]                i_enc_offset,
  input  logic [2:0]                i_enc_match_len,
  input  logic [7:0]                i_enc_char_nxt,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [$clog2(NUM_CH)-1:0] o_out_ch,
  output logic [3:0]                o_out_offset,
  output logic [2:0]                o_out_match_len,
  output logic [7:0]                o_out_char_nxt,
  output logic                      o_out_last,
  output logic                      o_err
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(BLOCK_LEN);
  localparam int TR_W  = $bits(triplet_t);
  localparam int ENT_W = CH_W + TR_W;

  sched_state_e      r_state;
  sched_state_e      w_state_nxt;
  logic [CH_W-1:0]   r_g;          // granted channel
  logic [CH_W-1:0]   r_rr;         // last granted channel
  logic              r_gnt_vld;
  logic [CNT_W-1:0]  r_cnt;
  logic [NUM_CH-1:0] r_done;
  logic              r_err;

  logic [CH_W-1:0]   w_pick;
  logic [CH_W-1:0]   w_idx;
  logic              w_pick_vld;
  logic [NUM_CH-1:0] w_g_onehot;
  logic              w_gch_valid;
  logic              w_underrun;
  logic              w_last_char;
  logic              w_timeout;
  logic              w_push;
  logic              w_overflow;
  logic              w_job_end;
  logic              w_full;
  logic              w_empty;
  triplet_t          w_trip;
  logic [ENT_W-1:0]  w_head;
  triplet_t          w_head_trip;

  assign w_g_onehot  = NUM_CH'(1) << r_g;
  assign w_gch_valid = i_ch_valid[r_g];
  assign w_underrun  = (r_state == LOAD) && !w_gch_valid;
  assign w_last_char = (r_state == LOAD) && w_gch_valid && (r_cnt == CNT_W'(BLOCK_LEN-1));
  assign w_push      = (r_state == ENCODE) && i_enc_valid;
  // Dropped push: FIFO full and the head is not leaving this cycle.
  assign w_overflow  = w_push && w_full && !(i_out_ready && !w_empty);
  assign w_job_end   = w_underrun || w_timeout || ((r_state == DRAIN) && w_empty);

  // Round-robin pick: scan from farthest to nearest after r_rr so the
  // nearest requester wins.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = '0;
    w_idx      = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      w_idx = CH_W'((int'(r_rr) + k) % NUM_CH);
      if (i_ch_req[w_idx]) begin
        w_pick_vld = 1'b1;
        w_pick     = w_idx;
      end
    end
  end

`ifdef LZ_SCHED_TIMEOUT_EN
  logic [15:0] r_to;

  assign w_timeout = (r_state == ENCODE) && !i_enc_finish && (r_to == 16'(TIMEOUT_CYC-1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                  r_to <= '0;
    else if (w_last_char)         r_to <= '0;
    else if (r_state == ENCODE)   r_to <= r_to + 16'd1;
  end
`else
  // Watchdog compiled out; the term is constant 0 for any legal TIMEOUT_CYC.
  assign w_timeout = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    o_enc_rst      = 1'b0;
    o_ch_ready     = '0;
    o_enc_chardata = 8'h00;
    case (r_state)
      IDLE: begin
        o_enc_rst = 1'b1;
        if (|i_ch_req) w_state_nxt = ARB;
      end
      ARB: begin
        o_enc_rst   = 1'b1;
        w_state_nxt = w_pick_vld ? RST : IDLE;
      end
      RST: w_state_nxt = LOAD;
      LOAD: begin
        o_ch_ready[r_g] = w_gch_valid;
        o_enc_chardata  = i_ch_data[{r_g, 3'b000} +: 8];
        if (w_underrun)       w_state_nxt = IDLE;
        else if (w_last_char) w_state_nxt = ENCODE;
      end
      ENCODE: begin
        if (w_timeout)         w_state_nxt = IDLE;
        else if (i_enc_finish) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_empty) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_g       <= '0;
      r_rr      <= CH_W'(NUM_CH-1);
      r_gnt_vld <= 1'b0;
      r_cnt     <= '0;
      r_done    <= '0;
      r_err     <= 1'b0;
    end else begin
      r_done <= '0;
      r_err  <= w_underrun || w_timeout || w_overflow;
      if ((r_state == ARB) && w_pick_vld) begin
        r_g       <= w_pick;
        r_rr      <= w_pick;
        r_gnt_vld <= 1'b1;
      end
      if (r_state == RST)
        r_cnt <= '0;
      else if ((r_state == LOAD) && w_gch_valid)
        r_cnt <= r_cnt + CNT_W'(1);
      if (w_job_end) begin
        r_done    <= w_g_onehot;
        r_gnt_vld <= 1'b0;
      end
    end
  end

  assign o_ch_gnt  = r_gnt_vld ? w_g_onehot : '0;
  assign o_ch_done = r_done;
  assign o_err     = r_err;

  assign w_trip.offset    = i_enc_offset;
  assign w_trip.match_len = i_enc_match_len;
  assign w_trip.char_nxt  = i_enc_char_nxt;

  lz77_triplet_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_reset),
    .i_flush (w_timeout),
    .i_push  (w_push),
    .i_wdata ({r_g, w_trip}),
    .i_pop   (i_out_ready),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Head fields read as zero while the FIFO is empty.
  assign w_head_trip     = w_empty ? '0 : triplet_t'(w_head[TR_W-1:0]);
  assign o_out_valid     = !w_empty;
  assign o_out_ch        = w_empty ? '0 : w_head[ENT_W-1 -: CH_W];
  assign o_out_offset    = w_head_trip.offset;
  assign o_out_match_len = w_head_trip.match_len;
  assign o_out_char_nxt  = w_head_trip.char_nxt;
  assign o_out_last      = !w_empty && (w_head_trip.char_nxt == LZ_EOS);

endmodule
`default_nettype wire

// File: tb/tb_lz77_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_lz77_job_scheduler
// Description : Self-checking bench for lz77_job_scheduler. The bench plays
//               the requesting channels and the encoder; a queue models the
//               output FIFO contents and a monitor compares every popped head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lz77_job_scheduler;

  localparam int NUM_CH = 2;
  localparam int BLEN   = 2048;
  localparam int DEPTH  = 4;
  localparam int TO_CYC = 300;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] ch_req;
  logic [NUM_CH*8-1:0] ch_data;
  logic [NUM_CH-1:0] ch_valid;
  logic [NUM_CH-1:0] ch_gnt, ch_ready, ch_done;
  logic              enc_rst;
  logic [7:0]        enc_chardata;
  logic              enc_valid, enc_finish;
  logic [3:0]        enc_offset;
  logic [2:0]        enc_match_len;
  logic [7:0]        enc_char_nxt;
  logic              out_valid, out_ready;
  logic [0:0]        out_ch;
  logic [3:0]        out_offset;
  logic [2:0]        out_match_len;
  logic [7:0]        out_char_nxt;
  logic              out_last;
  logic              err;

  lz77_job_scheduler #(
    .NUM_CH(NUM_CH), .BLOCK_LEN(BLEN), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_ch_req(ch_req), .i_ch_data(ch_data),
    .i_ch_valid(ch_valid), .o_ch_gnt(ch_gnt), .o_ch_ready(ch_ready),
    .o_ch_done(ch_done), .o_enc_rst(enc_rst), .o_enc_chardata(enc_chardata),
    .i_enc_valid(enc_valid), .i_enc_finish(enc_finish), .i_enc_offset(enc_offset),
    .i_enc_match_len(enc_match_len), .i_enc_char_nxt(enc_char_nxt),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_ch(out_ch),
    .o_out_offset(out_offset), .o_out_match_len(out_match_len),
    .o_out_char_nxt(out_char_nxt), .o_out_last(out_last), .o_err(err)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; int off; int len; int chr; } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int rr_model;
  int idx [NUM_CH];
  bit stall;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] chfun(input int c, input int i);
    return (c == 0) ? 8'(i % 16) : 8'(i * 7 + 3 + c);
  endfunction

  // Next requester strictly after the last granted channel, wrapping.
  function automatic int model_pick(input logic [NUM_CH-1:0] req, input int last);
    for (int k = 1; k <= NUM_CH; k++)
      if (req[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
    return -1;
  endfunction

  // Monitor: every DUT pop is compared with the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL fifo_unexpected actual=ch%0d/%0h required=empty", out_ch, out_char_nxt);
        end else begin
          e = exp_q.pop_front();
          check("out_ch",        out_ch,        e.ch);
          check("out_offset",    out_offset,    e.off);
          check("out_match_len", out_match_len, e.len);
          check("out_char_nxt",  out_char_nxt,  e.chr);
          check("out_last",      out_last,      (e.chr == 'h24) ? 1 : 0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    out_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    for (int c = 0; c < NUM_CH; c++) ch_data[8*c +: 8] = chfun(c, idx[c]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},      ch_gnt, 0);
    check({tag, "_ready"},    ch_ready, 0);
    check({tag, "_done"},     ch_done, 0);
    check({tag, "_enc_rst"},  enc_rst, 1);
    check({tag, "_chardata"}, enc_chardata, 0);
    check({tag, "_outvalid"}, out_valid, 0);
    check({tag, "_err"},      err, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    step();
    rst = 1'b0;
    rr_model = NUM_CH - 1;
    exp_q.delete();
  endtask

  // One complete job as seen from the requesters and the encoder.
  task automatic run_job(input int under_at, input int n_trip, input bit stall_enc,
                         input bit to_mode, input logic [NUM_CH-1:0] rereq);
    int g, n, waited, t, k;
    bit drop, seen, pop_now;
    exp_t e;
    g = model_pick(ch_req, rr_model);
    waited = 0;
    while (ch_gnt == 0 && waited < 10) begin step(); waited++; end
    check("grant", ch_gnt, (g < 0) ? 0 : (1 << g));
    if (ch_gnt == 0 || g < 0) return;
    rr_model = g;
    check("enc_rst_low_in_rst", enc_rst, 0);
    check("chardata_zero_in_rst", enc_chardata, 0);
    ch_req = ch_req | rereq;
    idx[g] = 0;
    n = 0; waited = 0;
    while (n < BLEN && waited < BLEN + 20) begin
      step(); waited++;
      ch_valid = '1;
      if (n == under_at) ch_valid[g] = 1'b0;
      #2;
      check("ready_other_ch", ch_ready & ~(NUM_CH'(1) << g), 0);
      if (n == under_at) begin
        check("ready_underrun", ch_ready, 0);
        step();
        check("underrun_done",    ch_done, 1 << g);
        check("underrun_err",     err, 1);
        check("underrun_enc_rst", enc_rst, 1);
        check("underrun_gnt",     ch_gnt, 0);
        check("underrun_fifo",    out_valid, 0);
        ch_req[g] = 1'b0;
        ch_valid  = '1;
        return;
      end
      if (ch_ready[g]) begin
        if (enc_chardata != chfun(g, n)) check("chardata", enc_chardata, chfun(g, n));
        n++;
        idx[g] = n;
      end
    end
    check("load_chars", n, BLEN);
    stall = stall_enc;
    drop = 0; t = 0; waited = 0;
    while (t < n_trip && waited < n_trip * 4 + 20) begin
      step(); waited++;
      check("err_encode", err, drop);
      drop = 0;
      enc_valid = 1'b0;
      if ($urandom_range(0, 3) != 0) begin
        e.ch  = g;
        e.off = int'($urandom_range(0, 15));
        e.len = int'($urandom_range(0, 7));
        e.chr = (t == n_trip - 1) ? 'h24 : int'($urandom_range(0, 255));
        enc_valid = 1'b1; enc_offset = 4'(e.off);
        enc_match_len = 3'(e.len); enc_char_nxt = 8'(e.chr);
        pop_now = (exp_q.size() > 0) && out_ready;
        if (exp_q.size() == DEPTH && !pop_now) drop = 1;
        else exp_q.push_back(e);
        t++;
      end
    end
    step();
    check("err_encode_tail", err, drop);
    enc_valid = 1'b0;
    if (to_mode) begin
      k = 1; seen = 0;
      while (!seen && k <= TO_CYC + 10) begin
        if (ch_done != 0) seen = 1;
        else begin step(); k++; end
      end
      check("timeout_cycles", k, TO_CYC + 1);
      check("timeout_done", ch_done, 1 << g);
      check("timeout_err", err, 1);
      check("timeout_fifo", out_valid, 0);
      exp_q.delete();
    end else begin
      enc_finish = 1'b1;
      step();
      enc_finish = 1'b0;
      stall = 1'b0;
      seen = 0; waited = 0;
      while (!seen && waited < 200) begin
        step(); waited++;
        if (ch_done != 0) seen = 1;
      end
      check("drain_done",    ch_done, 1 << g);
      check("drain_gnt",     ch_gnt, 0);
      check("drain_enc_rst", enc_rst, 1);
      check("drain_err",     err, 0);
      check("drain_model_q", exp_q.size(), 0);
    end
    stall = 1'b0;
    ch_req[g] = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ch_req = '0; ch_data = '0; ch_valid = '0;
    enc_valid = 0; enc_finish = 0; enc_offset = 0; enc_match_len = 0; enc_char_nxt = 0;
    out_ready = 0; stall = 0;
    for (int c = 0; c < NUM_CH; c++) idx[c] = 0;
    do_reset();

    // single requester, full job
    ch_req = 2'b01;
    run_job(-1, 20, 1'b0, 1'b0, '0);

    // simultaneous requests from reset, then ch0 re-requests during ch1 job
    do_reset();
    ch_req = 2'b11;
    run_job(-1, 8, 1'b0, 1'b0, '0);
    run_job(-1, 8, 1'b0, 1'b0, 2'b01);
    run_job(-1, 8, 1'b0, 1'b0, '0);

    // underrun at char 100 on channel 1
    ch_req = 2'b10;
    run_job(100, 0, 1'b0, 1'b0, '0);
    step();
    check("post_underrun_idle_enc_rst", enc_rst, 1);

    // output stalled through ENCODE: two pushes beyond depth are dropped
    ch_req = 2'b01;
    run_job(-1, 6, 1'b1, 1'b0, '0);

    // reset mid-LOAD
    ch_req = 2'b01;
    repeat (3) step();
    repeat (50) step();
    ch_valid = '1;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    step();
    rst = 1'b0;
    rr_model = NUM_CH - 1;
    exp_q.delete();
    #1;
    check("no_done_after_reset", ch_done, 0);
    run_job(-1, 10, 1'b0, 1'b0, '0);

`ifdef LZ_SCHED_TIMEOUT_EN
    ch_req = 2'b01;
    run_job(-1, 0, 1'b1, 1'b1, '0);
`endif

    repeat (5) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
